// File: rtl/mesi_pkg.sv
// mesi_pkg: MESI line-state codes, snoop-bus command codes and the miss-controller FSM states.
package mesi_pkg;
  localparam logic [1:0] MESI_I = 2'b00;
  localparam logic [1:0] MESI_S = 2'b01;
  localparam logic [1:0] MESI_E = 2'b10;
  localparam logic [1:0] MESI_M = 2'b11;
  localparam logic [1:0] BUS_NONE = 2'b00;
  localparam logic [1:0] BUS_RD   = 2'b01;
  localparam logic [1:0] BUS_RDX  = 2'b10;
  localparam logic [1:0] BUS_UPGR = 2'b11;
  typedef enum logic [2:0] {IDLE, WB, ARB, RESP, FILL, DONE} miss_state_e;
endpackage

// File: rtl/mesi_resp_timer.sv
// mesi_resp_timer: loadable down-counter; expired flags the last enabled cycle before reaching zero.
// Only built with MESI_MISS_TIMEOUT_EN, the only configuration that instantiates it.
`ifdef MESI_MISS_TIMEOUT_EN
module mesi_resp_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         expired
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? load_val : (en && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign expired = en && cnt_q == W'(1);
endmodule
`endif

// File: rtl/mesi_miss_controller.sv
// mesi_miss_controller: sequences writeback, bus request and fill for a cache line's misses and S->M upgrades.
// MESI_MISS_TIMEOUT_EN adds a RESP timeout that sets sticky err and completes without a fill.
module mesi_miss_controller
  import mesi_pkg::*;
#(
  parameter int TAG_WIDTH      = 20,
  parameter int LINE_SIZE      = 32,
  parameter int TIMEOUT_CYCLES = 256,
  localparam int LINE_BITS     = LINE_SIZE*8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cpu_req_valid,
  input  logic                 cpu_req_write,
  input  logic [TAG_WIDTH-1:0] cpu_req_tag,
  output logic                 cpu_req_ready,
  input  logic [1:0]           line_state,
  input  logic                 line_hit,
  input  logic [LINE_BITS-1:0] line_wb_data,
  input  logic [TAG_WIDTH-1:0] line_wb_tag,
  output logic                 fill_valid,
  output logic [LINE_BITS-1:0] fill_data,
  output logic [TAG_WIDTH-1:0] fill_tag,
  output logic                 fill_exclusive,
  output logic                 bus_req,
  input  logic                 bus_gnt,
  output logic [1:0]           bus_cmd,
  output logic [TAG_WIDTH-1:0] bus_tag,
  input  logic                 bus_shared,
  input  logic                 bus_resp_valid,
  input  logic [LINE_BITS-1:0] bus_resp_data,
  output logic                 mem_wb_valid,
  input  logic                 mem_wb_ready,
  output logic [LINE_BITS-1:0] mem_wb_data,
  output logic [TAG_WIDTH-1:0] mem_wb_tag,
  output logic                 busy,
  output logic                 err
);
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end
  miss_state_e state_q, state_d;
  logic [1:0] cmd_q, cmd_d;
  logic [TAG_WIDTH-1:0] tag_q, tag_d, wb_tag_q, wb_tag_d;
  logic [LINE_BITS-1:0] data_q, data_d, wb_data_q, wb_data_d;
  logic excl_q, excl_d, fill_valid_q, fill_valid_d, ready_q, ready_d;
  logic timeout;
`ifdef MESI_MISS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  logic err_q, err_d;
  mesi_resp_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (state_q == ARB),
    .en       (state_q == RESP),
    .load_val (TW'(TIMEOUT_CYCLES - 1)),
    .expired  (timeout)
  );
  always_comb err_d = err_q | (state_q == RESP && !bus_resp_valid && timeout);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) err_q <= 1'b0;
    else err_q <= err_d;
  assign err = err_q;
`else
  assign timeout = 1'b0;
  assign err = 1'b0;
`endif
  // The request is still held during the ready pulse, so IDLE must not re-accept it then.
  always_comb begin
    state_d = state_q;
    cmd_d = cmd_q;
    tag_d = tag_q;
    wb_tag_d = wb_tag_q;
    wb_data_d = wb_data_q;
    data_d = data_q;
    excl_d = excl_q;
    fill_valid_d = state_q == FILL;
    ready_d = state_q == DONE;
    case (state_q)
      IDLE: if (cpu_req_valid && !ready_q) begin
        tag_d = cpu_req_tag;
        cmd_d = cpu_req_write ? BUS_RDX : BUS_RD;
        if (line_hit && !(cpu_req_write && line_state == MESI_S)) state_d = DONE;
        else if (line_hit) begin
          cmd_d = BUS_UPGR;
          state_d = ARB;
        end else if (line_state == MESI_M) begin
          wb_tag_d = line_wb_tag;
          wb_data_d = line_wb_data;
          state_d = WB;
        end else state_d = ARB;
      end
      WB: if (mem_wb_ready) state_d = ARB;
      ARB: if (bus_gnt) state_d = cmd_q == BUS_UPGR ? DONE : RESP;
      RESP: if (bus_resp_valid) begin
        data_d = bus_resp_data;
        excl_d = cmd_q == BUS_RDX || !bus_shared;
        state_d = FILL;
      end else if (timeout) state_d = DONE;
      FILL: state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cmd_q <= BUS_NONE;
      tag_q <= '0;
      wb_tag_q <= '0;
      wb_data_q <= '0;
      data_q <= '0;
      excl_q <= 1'b0;
      fill_valid_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q <= cmd_d;
      tag_q <= tag_d;
      wb_tag_q <= wb_tag_d;
      wb_data_q <= wb_data_d;
      data_q <= data_d;
      excl_q <= excl_d;
      fill_valid_q <= fill_valid_d;
      ready_q <= ready_d;
    end
  assign cpu_req_ready = ready_q;
  assign fill_valid = fill_valid_q;
  assign fill_data = data_q;
  assign fill_tag = tag_q;
  assign fill_exclusive = excl_q;
  assign bus_req = state_q == ARB;
  assign bus_cmd = (state_q == ARB && bus_gnt) ? cmd_q : BUS_NONE;
  assign bus_tag = (state_q == ARB && bus_gnt) ? tag_q : '0;
  assign mem_wb_valid = state_q == WB;
  assign mem_wb_data = wb_data_q;
  assign mem_wb_tag = wb_tag_q;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_mesi_miss_controller.sv
// tb_mesi_miss_controller: directed cycle-by-cycle checks of the miss controller with hand-derived expectations.
module tb_mesi_miss_controller;
  import mesi_pkg::*;
  localparam int TW = 20;
  localparam int LB = 256;
  logic clk = 1'b0, rst_n = 1'b1;
  logic cpu_req_valid, cpu_req_write, cpu_req_ready, line_hit, fill_valid, fill_exclusive;
  logic bus_req, bus_gnt, bus_shared, bus_resp_valid, mem_wb_valid, mem_wb_ready, busy, err;
  logic [1:0] line_state, bus_cmd;
  logic [TW-1:0] cpu_req_tag, line_wb_tag, fill_tag, bus_tag, mem_wb_tag;
  logic [LB-1:0] line_wb_data, fill_data, bus_resp_data, mem_wb_data;
  logic [LB-1:0] d1, d2, d3, d4;
  int checks = 0, errors = 0, n;

  mesi_miss_controller #(.TAG_WIDTH(TW), .LINE_SIZE(32), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req_valid(cpu_req_valid), .cpu_req_write(cpu_req_write), .cpu_req_tag(cpu_req_tag),
    .cpu_req_ready(cpu_req_ready), .line_state(line_state), .line_hit(line_hit),
    .line_wb_data(line_wb_data), .line_wb_tag(line_wb_tag), .fill_valid(fill_valid),
    .fill_data(fill_data), .fill_tag(fill_tag), .fill_exclusive(fill_exclusive),
    .bus_req(bus_req), .bus_gnt(bus_gnt), .bus_cmd(bus_cmd), .bus_tag(bus_tag),
    .bus_shared(bus_shared), .bus_resp_valid(bus_resp_valid), .bus_resp_data(bus_resp_data),
    .mem_wb_valid(mem_wb_valid), .mem_wb_ready(mem_wb_ready), .mem_wb_data(mem_wb_data),
    .mem_wb_tag(mem_wb_tag), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [LB-1:0] obs, input logic [LB-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic w, input logic [TW-1:0] t, input logic [1:0] st, input logic h);
    cpu_req_valid = 1'b1;
    cpu_req_write = w;
    cpu_req_tag = t;
    line_state = st;
    line_hit = h;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    d1 = {8{32'hDEADBEEF}};
    d2 = {8{32'h0BADF00D}};
    d3 = {8{32'hCAFE1234}};
    d4 = {8{32'h55AA33CC}};
    {cpu_req_valid, cpu_req_write, line_hit, bus_gnt, bus_shared, bus_resp_valid, mem_wb_ready} = '0;
    cpu_req_tag = '0; line_state = MESI_I; line_wb_data = '0; line_wb_tag = '0; bus_resp_data = '0;
    #2 rst_n = 1'b0;
    step; step;
    chk("rst_ctl", {busy, cpu_req_ready, fill_valid, fill_exclusive, bus_req, bus_cmd, mem_wb_valid, err}, '0);
    chk("rst_tags", {fill_tag, bus_tag, mem_wb_tag}, '0);
    chk("rst_fill_data", fill_data, '0);
    chk("rst_wb_data", mem_wb_data, '0);
    rst_n = 1'b1;
    step;

    req(1'b0, 20'hABCDE, MESI_I, 1'b0);
    #1 chk("a_busy_idle", busy, 0);
    step;
    chk("a_bus_req", bus_req, 1);
    chk("a_cmd_nogrant", bus_cmd, BUS_NONE);
    bus_gnt = 1'b1;
    #1 chk("a_cmd", bus_cmd, BUS_RD);
    chk("a_bus_tag", bus_tag, 20'hABCDE);
    step;
    bus_gnt = 1'b0;
    chk("a_req_drop", bus_req, 0);
    step; step;
    bus_resp_valid = 1'b1; bus_resp_data = d1; bus_shared = 1'b0;
    step;
    bus_resp_valid = 1'b0; bus_resp_data = '0;
    chk("a_fill_early", fill_valid, 0);
    step;
    chk("a_fill", fill_valid, 1);
    chk("a_fill_excl", fill_exclusive, 1);
    chk("a_fill_data", fill_data, d1);
    chk("a_fill_tag", fill_tag, 20'hABCDE);
    chk("a_ready_early", cpu_req_ready, 0);
    step;
    chk("a_ready", cpu_req_ready, 1);
    chk("a_fill_pulse", fill_valid, 0);
    cpu_req_valid = 1'b0;
    step;
    chk("a_ready_pulse", cpu_req_ready, 0);
    chk("a_idle", busy, 0);

    req(1'b0, 20'h00F0F, MESI_I, 1'b0);
    step;
    bus_gnt = 1'b1;
    step;
    bus_gnt = 1'b0; bus_resp_valid = 1'b1; bus_shared = 1'b1; bus_resp_data = d2;
    step;
    bus_resp_valid = 1'b0; bus_shared = 1'b0; bus_resp_data = '0;
    step;
    chk("b_fill", fill_valid, 1);
    chk("b_fill_excl", fill_exclusive, 0);
    chk("b_fill_data", fill_data, d2);
    step;
    chk("b_ready", cpu_req_ready, 1);
    cpu_req_valid = 1'b0;
    step;

    req(1'b1, 20'h11111, MESI_S, 1'b1);
    step;
    bus_gnt = 1'b1;
    #1 chk("c_cmd", bus_cmd, BUS_UPGR);
    step;
    bus_gnt = 1'b0;
    chk("c_no_fill", fill_valid, 0);
    chk("c_ready_early", cpu_req_ready, 0);
    chk("c_req_drop", bus_req, 0);
    step;
    chk("c_ready", cpu_req_ready, 1);
    chk("c_no_fill2", fill_valid, 0);
    cpu_req_valid = 1'b0;
    step;
    chk("c_idle", busy, 0);

    req(1'b1, 20'h22222, MESI_M, 1'b0);
    line_wb_tag = 20'h12345; line_wb_data = d3;
    step;
    line_wb_tag = '0; line_wb_data = '0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_wb_ready = 1'b1;
      chk("d_wb_valid", mem_wb_valid, 1);
      chk("d_wb_tag", mem_wb_tag, 20'h12345);
      chk("d_wb_data", mem_wb_data, d3);
      chk("d_no_bus_req", bus_req, 0);
      step;
    end
    mem_wb_ready = 1'b0;
    chk("d_wb_done", mem_wb_valid, 0);
    chk("d_bus_req", bus_req, 1);
    bus_gnt = 1'b1;
    #1 chk("d_cmd", bus_cmd, BUS_RDX);
    chk("d_bus_tag", bus_tag, 20'h22222);
    step;
    bus_gnt = 1'b0; bus_resp_valid = 1'b1; bus_shared = 1'b1; bus_resp_data = d4;
    step;
    bus_resp_valid = 1'b0; bus_shared = 1'b0; bus_resp_data = '0;
    step;
    chk("d_fill", fill_valid, 1);
    chk("d_fill_excl", fill_exclusive, 1);
    chk("d_fill_data", fill_data, d4);
    chk("d_fill_tag", fill_tag, 20'h22222);
    step;
    chk("d_ready", cpu_req_ready, 1);
    cpu_req_valid = 1'b0;
    step;

    req(1'b0, 20'h33333, MESI_E, 1'b1);
    #1 chk("e_no_req0", bus_req, 0);
    step;
    chk("e_no_req1", bus_req, 0);
    chk("e_ready_early", cpu_req_ready, 0);
    step;
    chk("e_ready", cpu_req_ready, 1);
    chk("e_no_req2", bus_req, 0);
    cpu_req_valid = 1'b0;
    step;

    req(1'b0, 20'h44444, MESI_I, 1'b0);
    step;
    bus_gnt = 1'b1;
    step;
    bus_gnt = 1'b0;
    chk("f_busy_resp", busy, 1);
    #2 rst_n = 1'b0;
    #1 chk("f_rst_ctl", {busy, bus_req, fill_valid, cpu_req_ready, mem_wb_valid}, '0);
    chk("f_rst_tags", {fill_tag, mem_wb_tag}, '0);
    chk("f_rst_wb_data", mem_wb_data, '0);
    cpu_req_valid = 1'b0;
    step;
    rst_n = 1'b1; bus_resp_valid = 1'b1; bus_resp_data = d1;
    step;
    bus_resp_valid = 1'b0; bus_resp_data = '0;
    for (int i = 0; i < 4; i++) begin
      chk("f_after_rst", {fill_valid, cpu_req_ready, busy}, '0);
      step;
    end

`ifdef MESI_MISS_TIMEOUT_EN
    req(1'b0, 20'h55555, MESI_I, 1'b0);
    step;
    bus_gnt = 1'b1;
    step;
    bus_gnt = 1'b0;
    n = 0;
    while (!cpu_req_ready && n < 20) begin
      step;
      n++;
    end
    chk("g_timeout_cycles", n, 8);
    chk("g_err", err, 1);
    chk("g_no_fill", fill_valid, 0);
    cpu_req_valid = 1'b0;
    step; step;
    chk("g_err_sticky", err, 1);
`else
    chk("err_tied", err, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
